piece_scheduler: RTL and testbench
==================================

PIECE_SCHEDULER -- requirements
Module: piece_scheduler

Interface
REQ-001 SHALL have parameter GRAVITY_PERIOD, default 25000000, clk cycles between gravity ticks (>=16).
REQ-002 SHALL have parameter CHK_TIMEOUT, default 8, max cycles from chk_enable high to chk_complete.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port spawn / spawn_block  input  1 / 3  one-cycle pulse requesting a new piece of type spawn_block.
REQ-006 SHALL have port go_left / go_right  input  1 each  one-cycle move-request pulses.
REQ-007 SHALL have port chk_enable / chk_left / chk_right  output  1 each  collision-checker controls.
REQ-008 SHALL have port chk_complete / chk_collision  input  1 each  checker done strobe and result.
REQ-009 SHALL have port chk_X / chk_Y  input  5 / 6  checker-proposed anchor.
REQ-010 SHALL have port X_anchor / Y_anchor / block  output  5 / 6 / 3  committed active-piece state.
REQ-011 SHALL have port landed  output  1  one-cycle pulse when the active piece can no longer fall.
REQ-012 SHALL have port busy / err  output  1 each  piece active / checker timeout, err sticky until reset.

Function
REQ-013 FSM states IDLE, SETUP, CHECK, COMMIT, LAND; IDLE ignores move and tick requests.
REQ-014 IDLE + spawn: load block=spawn_block, X_anchor=4, Y_anchor=0, clear pending requests, go SETUP; busy=1.
REQ-015 go_left, go_right and gravity tick each set a sticky pending bit, cleared only when serviced.
REQ-016 Service priority at SETUP entry: left > right > gravity; both left and right pending simultaneously clears both, no move.
REQ-017 SETUP: chk_enable=0 exactly 1 cycle with chk_left/chk_right driven for the selected request (both 0 for gravity); go CHECK.
REQ-018 CHECK: chk_enable=1, chk_left/chk_right held stable until chk_complete.
REQ-019 On chk_complete go COMMIT: X_anchor<=chk_X, Y_anchor<=chk_Y, clear serviced pending bit.
REQ-020 Gravity check with chk_collision=1 goes LAND instead: anchor unchanged, landed=1 one cycle, then IDLE, busy=0.
REQ-021 COMMIT returns to SETUP if any pending bit is set, else waits in COMMIT with chk_enable=0.
REQ-022 CHECK timeout: chk_complete absent for CHK_TIMEOUT cycles sets err, drops chk_enable, returns IDLE.
REQ-023 Gravity counter runs only while busy, wraps at GRAVITY_PERIOD-1 producing one tick; restarts at 0 on spawn.
REQ-024 Requests arriving during CHECK are latched and serviced after COMMIT; spawn while busy is ignored.

Reset
REQ-025 resetn=0 asynchronously forces IDLE, pending bits=0, gravity counter=0, all outputs 0 (X_anchor, Y_anchor, block included).
REQ-026 Reset mid-CHECK drops chk_enable immediately; no commit occurs.

Configuration
REQ-027 Macro SOFT_DROP_EN: when defined, adds input go_down (1) setting the gravity pending bit and restarting the gravity counter; when undefined, port absent and only timer ticks drive gravity.

Structure
REQ-028 Shared package tetris_pkg holds the FSM state enum, BOARD_W=10, BOARD_H=24, SPAWN_X=4, SPAWN_Y=0.
REQ-029 Gravity counter SHALL be sub-module gravity_timer (clk, resetn, run, restart, tick).

Verification
REQ-030 spawn block=3 -> next cycle X_anchor=4, Y_anchor=0, block=3, busy=1.
REQ-031 GRAVITY_PERIOD=16, checker model returns Y+1 no collision -> Y_anchor increments every 16 cycles plus check latency.
REQ-032 go_left with chk_X=3 -> chk_left=1 during SETUP/CHECK, X_anchor=3 after complete, Y unchanged.
REQ-033 go_left and go_right same cycle -> no check issued, anchor unchanged.
REQ-034 gravity check returns chk_collision=1 -> landed pulse 1 cycle, busy=0, later go_left ignored.
REQ-035 checker never completes -> err=1 after 8 cycles, state IDLE; resetn low mid-CHECK -> all outputs 0 same cycle.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece scheduler.
//   - sched_state_t : scheduler FSM states (also exported on the debug port)
//   - req_t         : which pending request a check is servicing
//   - board geometry and spawn anchor constants
package tetris_pkg;

  localparam int         BOARD_W = 10;
  localparam int         BOARD_H = 24;
  localparam logic [4:0] SPAWN_X = 5'd4;
  localparam logic [5:0] SPAWN_Y = 6'd0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_LAND   = 3'd4
  } sched_state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_LEFT  = 2'd1,
    REQ_RIGHT = 2'd2,
    REQ_GRAV  = 2'd3
  } req_t;

endpackage

// File: rtl/gravity_timer.sv
// Gravity tick generator.
//   clk, resetn : clock, asynchronous active-low reset
//   run         : counter advances only while high
//   restart     : synchronous return to count 0 (has priority over run)
//   tick        : one-cycle pulse on the cycle the count sits at PERIOD-1
module gravity_timer #(
  parameter int PERIOD = 25000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // A restart in the wrap cycle swallows that tick: the period starts over.
  assign tick = run && !restart && (cnt == LAST);

endmodule

// File: rtl/piece_scheduler.sv
// Active-piece scheduler: holds the committed anchor/type of the falling
// piece and sequences move and gravity requests through an external
// collision checker, one request at a time.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   spawn, spawn_block[2:0]     new-piece request (accepted only when idle)
//   go_left, go_right           move request pulses (latched while busy)
//   go_down                     soft-drop pulse, only with SOFT_DROP_EN
//   chk_enable/left/right       checker controls
//   chk_complete/chk_collision  checker done strobe and result
//   chk_X[4:0], chk_Y[5:0]      checker-proposed anchor
//   X_anchor, Y_anchor, block   committed piece state
//   landed                      one-cycle pulse when the piece stops falling
//   busy                        a piece is active
//   err                         sticky checker-timeout flag
//   dbg_state                   current FSM state
//
// Checker handshake: chk_left/chk_right are valid from the SETUP cycle
// (chk_enable low) and stay stable while chk_enable is high in CHECK. The
// checker answers with a single-cycle chk_complete together with chk_X,
// chk_Y and chk_collision; the scheduler samples them on that cycle and
// drops chk_enable on the next. No chk_complete within CHK_TIMEOUT cycles
// of chk_enable going high aborts the piece and sets err.
//
// Build option: define SOFT_DROP_EN to add the go_down input.
module piece_scheduler
  import tetris_pkg::*;
#(
  parameter int GRAVITY_PERIOD = 25000000,
  parameter int CHK_TIMEOUT    = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         spawn,
  input  logic [2:0]   spawn_block,
  input  logic         go_left,
  input  logic         go_right,
`ifdef SOFT_DROP_EN
  input  logic         go_down,
`endif
  output logic         chk_enable,
  output logic         chk_left,
  output logic         chk_right,
  input  logic         chk_complete,
  input  logic         chk_collision,
  input  logic [4:0]   chk_X,
  input  logic [5:0]   chk_Y,
  output logic [4:0]   X_anchor,
  output logic [5:0]   Y_anchor,
  output logic [2:0]   block,
  output logic         landed,
  output logic         busy,
  output logic         err,
  output sched_state_t dbg_state
);

  localparam int             CTW      = (CHK_TIMEOUT > 1) ? $clog2(CHK_TIMEOUT) : 1;
  localparam logic [CTW-1:0] CHK_LAST = CTW'(CHK_TIMEOUT - 1);

  sched_state_t   state, state_d;
  req_t           sel_q, sel_d, svc;
  logic           pend_l, pend_r, pend_g;
  logic           set_l, set_r, set_g;
  logic           clr_l, clr_r, clr_g, clr_all;
  logic           load_spawn, do_commit, set_err;
  logic           active;
  logic           grav_tick, grav_restart;
  logic           chk_timeout;
  logic [CTW-1:0] chk_cnt;

  assign active = (state != ST_IDLE);

  // ---------------------------------------------------------------- gravity
`ifdef SOFT_DROP_EN
  logic soft_drop;
  assign soft_drop    = go_down && active;
  assign grav_restart = load_spawn || soft_drop;
  assign set_g        = grav_tick || soft_drop;
`else
  assign grav_restart = load_spawn;
  assign set_g        = grav_tick;
`endif

  gravity_timer #(
    .PERIOD (GRAVITY_PERIOD)
  ) u_gravity_timer (
    .clk     (clk),
    .resetn  (resetn),
    .run     (active),
    .restart (grav_restart),
    .tick    (grav_tick)
  );

  // Move requests are ignored while no piece is active.
  assign set_l = go_left  && active;
  assign set_r = go_right && active;

  // Request arbitration: left > right > gravity; left and right together
  // cancel each other and produce no check.
  always_comb begin
    svc = REQ_NONE;
    if (pend_l && pend_r) begin
      svc = REQ_NONE;
    end else if (pend_l) begin
      svc = REQ_LEFT;
    end else if (pend_r) begin
      svc = REQ_RIGHT;
    end else if (pend_g) begin
      svc = REQ_GRAV;
    end
  end

  // Checker time-out: counts CHECK cycles; the last allowed one is CHK_LAST.
  assign chk_timeout = !chk_complete && (chk_cnt == CHK_LAST);

  // ------------------------------------------------------ next state logic
  always_comb begin
    state_d    = state;
    sel_d      = sel_q;
    clr_l      = 1'b0;
    clr_r      = 1'b0;
    clr_g      = 1'b0;
    clr_all    = 1'b0;
    load_spawn = 1'b0;
    do_commit  = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (spawn) begin
          load_spawn = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (pend_l && pend_r) begin
          clr_l   = 1'b1;
          clr_r   = 1'b1;
          state_d = ST_COMMIT;
        end else if (svc != REQ_NONE) begin
          sel_d   = svc;
          state_d = ST_CHECK;
        end else begin
          // Nothing to service (fresh spawn): park until a request arrives.
          state_d = ST_COMMIT;
        end
      end
      ST_CHECK: begin
        if (chk_complete) begin
          if (sel_q == REQ_GRAV && chk_collision) begin
            state_d = ST_LAND;
            clr_all = 1'b1;
          end else begin
            do_commit = 1'b1;
            state_d   = ST_COMMIT;
            clr_l     = (sel_q == REQ_LEFT);
            clr_r     = (sel_q == REQ_RIGHT);
            clr_g     = (sel_q == REQ_GRAV);
          end
        end else if (chk_timeout) begin
          set_err = 1'b1;
          clr_all = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (pend_l || pend_r || pend_g) begin
          state_d = ST_SETUP;
        end
      end
      ST_LAND: begin
        clr_all = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      sel_q <= REQ_NONE;
    end else begin
      state <= state_d;
      sel_q <= sel_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chk_cnt <= '0;
    end else if (state == ST_CHECK) begin
      chk_cnt <= chk_cnt + 1'b1;
    end else begin
      chk_cnt <= '0;
    end
  end

  // A request arriving in the same cycle its bit is serviced stays pending;
  // abandoning the piece (land, time-out, new spawn) drops everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_l <= 1'b0;
      pend_r <= 1'b0;
      pend_g <= 1'b0;
    end else if (load_spawn || clr_all) begin
      pend_l <= 1'b0;
      pend_r <= 1'b0;
      pend_g <= 1'b0;
    end else begin
      pend_l <= set_l || (pend_l && !clr_l);
      pend_r <= set_r || (pend_r && !clr_r);
      pend_g <= set_g || (pend_g && !clr_g);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      X_anchor <= '0;
      Y_anchor <= '0;
      block    <= '0;
    end else if (load_spawn) begin
      X_anchor <= SPAWN_X;
      Y_anchor <= SPAWN_Y;
      block    <= spawn_block;
    end else if (do_commit) begin
      X_anchor <= chk_X;
      Y_anchor <= chk_Y;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (set_err) begin
      err <= 1'b1;
    end
  end

  // -------------------------------------------------------------- outputs
  // Direction is shown combinationally in SETUP from the arbiter and then
  // from the latched selection in CHECK, so it never glitches between them.
  assign chk_enable = (state == ST_CHECK);
  assign chk_left   = ((state == ST_SETUP) && (svc == REQ_LEFT)) ||
                      ((state == ST_CHECK) && (sel_q == REQ_LEFT));
  assign chk_right  = ((state == ST_SETUP) && (svc == REQ_RIGHT)) ||
                      ((state == ST_CHECK) && (sel_q == REQ_RIGHT));
  assign landed     = (state == ST_LAND);
  assign busy       = active;
  assign dbg_state  = state;

endmodule

// File: tb/tb_piece_scheduler.sv
// Bench for piece_scheduler: directed scenario sequence plus randomized
// move traffic, with a responsive collision-checker model whose proposals
// drive a reference anchor kept in the bench.
module tb_piece_scheduler;
  import tetris_pkg::*;

  localparam int GP = 16;
  localparam int CT = 8;

  // ---------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         spawn;
  logic [2:0]   spawn_block;
  logic         go_left, go_right;
`ifdef SOFT_DROP_EN
  logic         go_down;
`endif
  logic         chk_enable, chk_left, chk_right;
  logic         chk_complete, chk_collision;
  logic [4:0]   chk_X;
  logic [5:0]   chk_Y;
  logic [4:0]   X_anchor;
  logic [5:0]   Y_anchor;
  logic [2:0]   block;
  logic         landed, busy, err;
  sched_state_t dbg_state;

  piece_scheduler #(
    .GRAVITY_PERIOD (GP),
    .CHK_TIMEOUT    (CT)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .spawn         (spawn),
    .spawn_block   (spawn_block),
    .go_left       (go_left),
    .go_right      (go_right),
`ifdef SOFT_DROP_EN
    .go_down       (go_down),
`endif
    .chk_enable    (chk_enable),
    .chk_left      (chk_left),
    .chk_right     (chk_right),
    .chk_complete  (chk_complete),
    .chk_collision (chk_collision),
    .chk_X         (chk_X),
    .chk_Y         (chk_Y),
    .X_anchor      (X_anchor),
    .Y_anchor      (Y_anchor),
    .block         (block),
    .landed        (landed),
    .busy          (busy),
    .err           (err),
    .dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference piece state: committed whenever the checker model's answer
  // is accepted (complete without a gravity collision).
  logic [4:0] exp_x;
  logic [5:0] exp_y;
  logic [2:0] exp_block;
  int n_left = 0, n_right = 0, n_grav = 0, n_coll = 0;

  // Checker model controls
  int lat     = 1;
  bit hang    = 1'b0;
  bit collide = 1'b0;

  // ------------------------------------------------------- checker model
  // Proposes x-1 / x+1 / y+1 for left / right / gravity after `lat` extra
  // cycles; the answer is applied to the reference on the cycle after the
  // strobe, i.e. when the scheduler has taken it.
  initial begin : checker_model
    int wait_cnt;
    int kind;
    logic [4:0] px;
    logic [5:0] py;
    chk_complete  = 1'b0;
    chk_collision = 1'b0;
    chk_X         = '0;
    chk_Y         = '0;
    wait_cnt      = 0;
    kind          = 0;
    px            = '0;
    py            = '0;
    forever begin
      @(posedge clk);
      #1;
      if (chk_complete && resetn) begin
        if (kind == 2 && chk_collision) begin
          n_coll++;
        end else begin
          exp_x = px;
          exp_y = py;
          if (kind == 0) n_left++;
          else if (kind == 1) n_right++;
          else n_grav++;
        end
      end
      chk_complete  = 1'b0;
      chk_collision = 1'b0;
      if (chk_enable && !hang) begin
        if (wait_cnt >= lat) begin
          kind = chk_left ? 0 : (chk_right ? 1 : 2);
          px   = exp_x;
          py   = exp_y;
          if (kind == 0) px = exp_x - 5'd1;
          else if (kind == 1) px = exp_x + 5'd1;
          else py = exp_y + 6'd1;
          chk_X         = px;
          chk_Y         = py;
          chk_collision = (kind == 2) && collide;
          chk_complete  = 1'b1;
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ------------------------------------------------------- driver tasks
  task automatic do_spawn(input logic [2:0] b);
    @(posedge clk); #1;
    spawn = 1'b1;
    spawn_block = b;
    @(posedge clk); #1;
    spawn = 1'b0;
    exp_x = SPAWN_X;
    exp_y = SPAWN_Y;
    exp_block = b;
  endtask

  task automatic pulse(input bit l, input bit r);
    @(posedge clk); #1;
    go_left  = l;
    go_right = r;
    @(posedge clk); #1;
    go_left  = 1'b0;
    go_right = 1'b0;
  endtask

  task automatic wait_move_check(input string tag);
    int c;
    for (c = 0; c < 60 && !(chk_enable && (chk_left || chk_right)); c++) @(negedge clk);
    check({tag, "_check_issued"}, 32'(chk_enable), 32'd1);
  endtask

  task automatic wait_count_change(input int which, input int start);
    int c;
    int cur;
    cur = start;
    for (c = 0; c < 100 && cur == start; c++) begin
      @(negedge clk);
      cur = (which == 0) ? n_left : ((which == 1) ? n_right : n_grav);
    end
  endtask

  // -------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // -------------------------------------------------------- main sequence
  initial begin : main
    int l0, r0, g0, g1, cnt, c;
    logic [4:0] x0;
    logic [5:0] y0;
    resetn = 1'b0;
    spawn = 1'b0;
    spawn_block = '0;
    go_left = 1'b0;
    go_right = 1'b0;
`ifdef SOFT_DROP_EN
    go_down = 1'b0;
`endif
    exp_x = '0;
    exp_y = '0;
    exp_block = '0;

    // Reset values
    #3;
    check("rst_chk_enable", 32'(chk_enable), 32'd0);
    check("rst_chk_dir", 32'({chk_left, chk_right}), 32'd0);
    check("rst_x", 32'(X_anchor), 32'd0);
    check("rst_y", 32'(Y_anchor), 32'd0);
    check("rst_block", 32'(block), 32'd0);
    check("rst_flags", 32'({landed, busy, err}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_not_busy", 32'(busy), 32'd0);

    // Spawn block 3: anchor (4,0) on the next cycle
    do_spawn(3'd3);
    @(negedge clk);
    check("spawn_x", 32'(X_anchor), 32'd4);
    check("spawn_y", 32'(Y_anchor), 32'd0);
    check("spawn_block", 32'(block), 32'd3);
    check("spawn_busy", 32'(busy), 32'd1);

    // Gravity cadence with a fixed-latency checker: one drop per period
    lat = 2;
    g0 = n_grav;
    wait_count_change(2, g0);
    check("grav_first_drop", 32'(n_grav - g0), 32'd1);
    check("grav_first_y", 32'(Y_anchor), 32'd1);
    for (int k = 0; k < 2; k++) begin
      g1 = n_grav;
      cnt = 0;
      while (n_grav == g1 && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      check("grav_interval", 32'(cnt), 32'(GP));
      check("grav_y", 32'(Y_anchor), 32'(exp_y));
    end
    check("grav_y_after_three", 32'(Y_anchor), 32'd3);

    // Directed left move: checker proposes x=3
    x0 = exp_x;
    y0 = exp_y;
    l0 = n_left;
    pulse(1'b1, 1'b0);
    wait_move_check("left");
    check("left_dir", 32'({chk_left, chk_right}), 32'b10);
    wait_count_change(0, l0);
    check("left_serviced", 32'(n_left - l0), 32'd1);
    check("left_x", 32'(X_anchor), 32'(x0 - 5'd1));
    check("left_y", 32'(Y_anchor), 32'(exp_y));
    check("left_x_is_3", 32'(X_anchor), 32'd3);

    // Randomized single moves with random checker latency
    for (int i = 0; i < 10; i++) begin
      bit dir_r;
      dir_r = 1'($urandom_range(0, 1));
      if (exp_x <= 5'd1) dir_r = 1'b1;
      if (exp_x >= 5'd8) dir_r = 1'b0;
      lat = int'($urandom_range(0, 5));
      x0 = exp_x;
      l0 = n_left;
      r0 = n_right;
      pulse(!dir_r, dir_r);
      wait_count_change(dir_r ? 1 : 0, dir_r ? r0 : l0);
      check("rand_serviced", 32'((n_left - l0) + (n_right - r0)), 32'd1);
      check("rand_x", 32'(X_anchor), 32'(dir_r ? x0 + 5'd1 : x0 - 5'd1));
      check("rand_y", 32'(Y_anchor), 32'(exp_y));
    end

    // Request arriving during CHECK is serviced afterwards
    lat = 4;
    x0 = exp_x;
    l0 = n_left;
    r0 = n_right;
    pulse(1'b1, 1'b0);
    wait_move_check("queued_left");
    pulse(1'b0, 1'b1);
    wait_count_change(1, r0);
    check("queued_left_cnt", 32'(n_left - l0), 32'd1);
    check("queued_right_cnt", 32'(n_right - r0), 32'd1);
    check("queued_x_net", 32'(X_anchor), 32'(x0));

    // Left and right in the same cycle cancel: no move check
    lat = 1;
    x0 = exp_x;
    l0 = n_left;
    r0 = n_right;
    pulse(1'b1, 1'b1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (chk_enable && (chk_left || chk_right)) cnt++;
    end
    check("both_no_move_check", 32'(cnt), 32'd0);
    check("both_counts", 32'((n_left - l0) + (n_right - r0)), 32'd0);
    check("both_x", 32'(X_anchor), 32'(x0));

    // Gravity collision: landed pulse, piece released
    collide = 1'b1;
    for (c = 0; c < 80 && landed !== 1'b1; c++) @(negedge clk);
    check("land_pulse", 32'(landed), 32'd1);
    check("land_x", 32'(X_anchor), 32'(exp_x));
    check("land_y", 32'(Y_anchor), 32'(exp_y));
    @(negedge clk);
    collide = 1'b0;
    check("land_pulse_width", 32'(landed), 32'd0);
    check("land_busy", 32'(busy), 32'd0);
    check("land_state", 32'(dbg_state), 32'(ST_IDLE));
    x0 = exp_x;
    pulse(1'b1, 1'b0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (chk_enable) cnt++;
    end
    check("idle_ignores_left", 32'(cnt), 32'd0);
    check("idle_x_kept", 32'(X_anchor), 32'(x0));
    check("idle_block_kept", 32'(block), 32'(exp_block));

    // Checker never answers: time-out after CT cycles
    hang = 1'b1;
    do_spawn(3'($urandom_range(0, 7)));
    @(negedge clk);
    check("respawn_block", 32'(block), 32'(exp_block));
    for (c = 0; c < 60 && chk_enable !== 1'b1; c++) @(negedge clk);
    cnt = 0;
    while (chk_enable === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_len", 32'(cnt), 32'(CT));
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_state", 32'(dbg_state), 32'(ST_IDLE));
    check("timeout_busy", 32'(busy), 32'd0);

    // err stays set across a new piece
    hang = 1'b0;
    do_spawn(3'd5);
    repeat (5) @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    check("sticky_busy", 32'(busy), 32'd1);

    // Reset in the middle of a check clears everything at once
    hang = 1'b1;
    for (c = 0; c < 60 && chk_enable !== 1'b1; c++) @(negedge clk);
    check("midcheck_enable", 32'(chk_enable), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_chk_enable", 32'(chk_enable), 32'd0);
    check("arst_anchor", 32'({X_anchor, Y_anchor, block}), 32'd0);
    check("arst_flags", 32'({landed, busy, err}), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    hang = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'({busy, chk_enable}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
